// File: rtl/pe_operand_issuer_if.sv
// rtl/pe_operand_issuer_if.sv - operand streams, op control and PE-side bundle for the issuer
interface pe_operand_issuer_if #(
  parameter int DWIDTH       = 64,
  parameter int MAX_INFLIGHT = 16
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic [DWIDTH-1:0] s_inp1_tdata;
  logic              s_inp1_tvalid;
  logic              s_inp1_tready;
  logic [DWIDTH-1:0] s_inp2_tdata;
  logic              s_inp2_tvalid;
  logic              s_inp2_tready;
  logic [1:0]        cfg_op;
  logic              cfg_op_valid;
  logic              cfg_op_ready;
  logic [DWIDTH-1:0] inp1;
  logic [DWIDTH-1:0] inp2;
  logic              t_valid_inp1;
  logic              t_valid_inp2;
  logic [1:0]        op;
  logic              pe_result_valid;
  logic [IW-1:0]     inflight;
  logic              err_underflow;

  modport master (
    output s_inp1_tdata, s_inp1_tvalid, s_inp2_tdata, s_inp2_tvalid,
    output cfg_op, cfg_op_valid, pe_result_valid,
    input  s_inp1_tready, s_inp2_tready, cfg_op_ready,
    input  inp1, inp2, t_valid_inp1, t_valid_inp2, op, inflight, err_underflow
  );

  modport slave (
    input  s_inp1_tdata, s_inp1_tvalid, s_inp2_tdata, s_inp2_tvalid,
    input  cfg_op, cfg_op_valid, pe_result_valid,
    output s_inp1_tready, s_inp2_tready, cfg_op_ready,
    output inp1, inp2, t_valid_inp1, t_valid_inp2, op, inflight, err_underflow
  );
endinterface

// File: rtl/pe_operand_issuer.sv
// rtl/pe_operand_issuer.sv - pairs two operand FIFOs and issues aligned pairs to the PE
module pe_operand_issuer #(
  parameter int DWIDTH       = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 16
) (
  input logic               clk,
  input logic               rst,
  pe_operand_issuer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

  state_t            state_q;
  logic [DWIDTH-1:0] mem1_q [FIFO_DEPTH];
  logic [DWIDTH-1:0] mem2_q [FIFO_DEPTH];
  logic [PW-1:0]     wp1_q, rp1_q, wp2_q, rp2_q;
  logic              full1, full2, empty1, empty2, push1, push2;
  logic              op_change, issue;
  logic [DWIDTH-1:0] inp1_q, inp2_q;
  logic              tvalid_q, ready_q, err_q, err_d;
  logic [1:0]        op_q;
  logic [IW-1:0]     inflight_q, inflight_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full1  = (wp1_q[AW] != rp1_q[AW]) && (wp1_q[AW-1:0] == rp1_q[AW-1:0]);
  assign full2  = (wp2_q[AW] != rp2_q[AW]) && (wp2_q[AW-1:0] == rp2_q[AW-1:0]);
  assign empty1 = (wp1_q == rp1_q);
  assign empty2 = (wp2_q == rp2_q);
  assign push1  = bus.s_inp1_tvalid && !full1;
  assign push2  = bus.s_inp2_tvalid && !full2;

  assign op_change = (state_q == RUN) && bus.cfg_op_valid && (bus.cfg_op != op_q);
  assign issue     = (state_q == RUN) && !op_change && !empty1 && !empty2 &&
                     (inflight_q < MAX_CNT);

  always_ff @(posedge clk) begin
    if (push1) mem1_q[wp1_q[AW-1:0]] <= bus.s_inp1_tdata;
    if (push2) mem2_q[wp2_q[AW-1:0]] <= bus.s_inp2_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp1_q <= '0;
      rp1_q <= '0;
      wp2_q <= '0;
      rp2_q <= '0;
    end else begin
      if (push1) wp1_q <= wp1_q + PW'(1);
      if (push2) wp2_q <= wp2_q + PW'(1);
      if (issue) begin
        rp1_q <= rp1_q + PW'(1);
        rp2_q <= rp2_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inp1_q   <= '0;
      inp2_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tvalid_q <= issue;
      if (issue) begin
        inp1_q <= mem1_q[rp1_q[AW-1:0]];
        inp2_q <= mem2_q[rp2_q[AW-1:0]];
      end
    end
  end

  // A return with nothing outstanding is flagged and never wraps the counter.
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (issue && !bus.pe_result_valid) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!issue && bus.pe_result_valid) begin
      if (inflight_q == '0) err_d = 1'b1;
      else                  inflight_d = inflight_q - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // The ready guard keeps a still-held request from pulsing twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      op_q    <= 2'b00;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (op_change) state_q <= DRAIN;
          else if (bus.cfg_op_valid && !ready_q) ready_q <= 1'b1;
        end
        DRAIN: begin
          if (inflight_q == '0 && !tvalid_q) state_q <= LOAD;
        end
        LOAD: begin
          op_q    <= bus.cfg_op;
          ready_q <= 1'b1;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.s_inp1_tready = !full1;
  assign bus.s_inp2_tready = !full2;
  assign bus.inp1          = inp1_q;
  assign bus.inp2          = inp2_q;
  assign bus.t_valid_inp1  = tvalid_q;
  assign bus.t_valid_inp2  = tvalid_q;
  assign bus.op            = op_q;
  assign bus.cfg_op_ready  = ready_q;
  assign bus.inflight      = inflight_q;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_pe_operand_issuer.sv
// tb/tb_pe_operand_issuer.sv - scoreboard bench for pe_operand_issuer
module tb_pe_operand_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] D1_0 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D2_0 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D3_0 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D4_0 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D5_0 = 64'h4014_0000_0000_0000;
  localparam logic [63:0] D6_0 = 64'h4018_0000_0000_0000;

  pe_operand_issuer_if #(.DWIDTH(64), .MAX_INFLIGHT(16)) a ();
  pe_operand_issuer_if #(.DWIDTH(64), .MAX_INFLIGHT(2))  b ();

  pe_operand_issuer #(.DWIDTH(64), .FIFO_DEPTH(4), .MAX_INFLIGHT(16)) u_dut (
    .clk(clk), .rst(rst), .bus(a)
  );
  pe_operand_issuer #(.DWIDTH(64), .FIFO_DEPTH(4), .MAX_INFLIGHT(2)) u_dut_lim (
    .clk(clk), .rst(rst), .bus(b)
  );

  always #5 clk = ~clk;

  logic [63:0]  q1[$], q2[$], qb1[$], qb2[$];
  logic [127:0] obs_d[$];
  logic [1:0]   obs_op[$];
  int           obs_cyc[$];
  int           split_cnt, rdy_cnt;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_op.delete(); obs_cyc.delete();
    split_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic collect(input bit sel, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (!sel) begin
        if (a.t_valid_inp1 !== a.t_valid_inp2) split_cnt++;
        if (a.t_valid_inp1 === 1'b1) begin
          obs_d.push_back({a.inp1, a.inp2}); obs_op.push_back(a.op); obs_cyc.push_back(k);
        end
        if (a.cfg_op_ready === 1'b1) rdy_cnt++;
      end else begin
        if (b.t_valid_inp1 !== b.t_valid_inp2) split_cnt++;
        if (b.t_valid_inp1 === 1'b1) begin
          obs_d.push_back({b.inp1, b.inp2}); obs_op.push_back(b.op); obs_cyc.push_back(k);
        end
      end
    end
  endtask

  task automatic push_pair(input bit sel, input logic [63:0] d1, input logic [63:0] d2);
    bit got1, got2, r1, r2;
    got1 = 0; got2 = 0;
    if (sel) begin
      b.s_inp1_tdata = d1; b.s_inp2_tdata = d2; b.s_inp1_tvalid = 1; b.s_inp2_tvalid = 1;
    end else begin
      a.s_inp1_tdata = d1; a.s_inp2_tdata = d2; a.s_inp1_tvalid = 1; a.s_inp2_tvalid = 1;
    end
    for (int t = 0; t < 64 && !(got1 && got2); t++) begin
      r1 = sel ? b.s_inp1_tready : a.s_inp1_tready;
      r2 = sel ? b.s_inp2_tready : a.s_inp2_tready;
      @(posedge clk);
      if (!got1 && r1) begin
        got1 = 1;
        if (sel) qb1.push_back(d1); else q1.push_back(d1);
      end
      if (!got2 && r2) begin
        got2 = 1;
        if (sel) qb2.push_back(d2); else q2.push_back(d2);
      end
      #1;
      if (got1) begin if (sel) b.s_inp1_tvalid = 0; else a.s_inp1_tvalid = 0; end
      if (got2) begin if (sel) b.s_inp2_tvalid = 0; else a.s_inp2_tvalid = 0; end
    end
    if (!(got1 && got2)) begin
      vectors++; miscompares++;
      $display("FAIL push_pair_timeout accepted=%0d%0d required=11", got1, got2);
    end
  endtask

  task automatic push_one(input int stream, input logic [63:0] d);
    bit got, r;
    got = 0;
    if (stream == 1) begin a.s_inp1_tdata = d; a.s_inp1_tvalid = 1; end
    else begin a.s_inp2_tdata = d; a.s_inp2_tvalid = 1; end
    for (int t = 0; t < 64 && !got; t++) begin
      r = (stream == 1) ? a.s_inp1_tready : a.s_inp2_tready;
      @(posedge clk);
      if (r) begin
        got = 1;
        if (stream == 1) q1.push_back(d); else q2.push_back(d);
      end
      #1;
    end
    if (stream == 1) a.s_inp1_tvalid = 0; else a.s_inp2_tvalid = 0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL push_one_timeout stream=%0d accepted=0 required=1", stream);
    end
  endtask

  task automatic ret(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) b.pe_result_valid = 1; else a.pe_result_valid = 1;
      @(posedge clk); #1;
    end
    b.pe_result_valid = 0; a.pe_result_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q1.delete(); q2.delete(); qb1.delete(); qb2.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(3);
    rst = 0;
    @(negedge clk);
    vectors++;
    if ({a.s_inp1_tready, a.s_inp2_tready, a.t_valid_inp1, a.t_valid_inp2, a.op,
         a.cfg_op_ready, a.err_underflow} !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b required=11000000", {a.s_inp1_tready, a.s_inp2_tready,
               a.t_valid_inp1, a.t_valid_inp2, a.op, a.cfg_op_ready, a.err_underflow});
    end
    vectors++;
    if ({a.inp1, a.inp2} !== 128'd0 || a.inflight !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_data inp1=%h inp2=%h inflight=%0d required=0", a.inp1, a.inp2, a.inflight);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_pairs();
    logic [127:0] exp;
    clear_obs();
    fork
      begin
        push_pair(0, D1_0, D4_0);
        push_pair(0, D2_0, D5_0);
        push_pair(0, D3_0, D6_0);
      end
      collect(0, 8);
    join
    vectors++;
    if (obs_d.size() != 3) begin
      miscompares++; $display("FAIL basic_count got=%0d required=3", obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp = {q1.pop_front(), q2.pop_front()};
      vectors++;
      if (obs_d[i] !== exp || obs_op[i] !== 2'b00 || obs_cyc[i] != i + 2) begin
        miscompares++;
        $display("FAIL basic_pair%0d got=%h op=%0d cyc=%0d required=%h op=0 cyc=%0d",
                 i, obs_d[i], obs_op[i], obs_cyc[i], exp, i + 2);
      end
    end
    vectors++;
    if (a.inflight !== 5'd3 || split_cnt != 0) begin
      miscompares++; $display("FAIL basic_inflight got=%0d split=%0d required=3 split=0", a.inflight, split_cnt);
    end
    @(posedge clk); #1;
    ret(0, 3);
    @(negedge clk);
    vectors++;
    if (a.inflight !== 5'd0) begin
      miscompares++; $display("FAIL basic_drain got=%0d required=0", a.inflight);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lone_operand();
    logic [127:0] exp;
    clear_obs();
    fork
      begin push_one(1, 64'h11); push_one(1, 64'h12); push_one(1, 64'h13); end
      collect(0, 14);
    join
    vectors++;
    if (obs_d.size() != 0) begin
      miscompares++; $display("FAIL lone_no_issue got=%0d pairs required=0", obs_d.size());
    end
    @(posedge clk); #1;
    fork push_one(2, 64'h21); collect(0, 6); join
    vectors++;
    if (obs_d.size() != 1) begin
      miscompares++; $display("FAIL lone_single got=%0d pairs required=1", obs_d.size());
    end
    @(posedge clk); #1;
    fork begin push_one(2, 64'h22); push_one(2, 64'h23); end collect(0, 8); join
    vectors++;
    if (obs_d.size() != 3) begin
      miscompares++; $display("FAIL lone_rest got=%0d pairs required=3", obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp = {q1.pop_front(), q2.pop_front()};
      vectors++;
      if (obs_d[i] !== exp) begin
        miscompares++; $display("FAIL lone_pair%0d got=%h required=%h", i, obs_d[i], exp);
      end
    end
    vectors++;
    if (split_cnt != 0 || a.inflight !== 5'd3) begin
      miscompares++; $display("FAIL lone_split split=%0d inflight=%0d required=0,3", split_cnt, a.inflight);
    end
    @(posedge clk); #1;
    ret(0, 3);
  endtask

  task automatic test_inflight_limit();
    logic [127:0] exp;
    clear_obs();
    fork
      for (int i = 0; i < 5; i++) push_pair(1, 64'h100 + 64'(i), 64'h200 + 64'(i));
      collect(1, 16);
    join
    vectors++;
    if (obs_d.size() != 2 || b.inflight !== 2'd2) begin
      miscompares++; $display("FAIL limit_hold got=%0d pairs inflight=%0d required=2,2", obs_d.size(), b.inflight);
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp = {qb1.pop_front(), qb2.pop_front()};
      vectors++;
      if (obs_d[i] !== exp) begin
        miscompares++; $display("FAIL limit_pair%0d got=%h required=%h", i, obs_d[i], exp);
      end
    end
    @(posedge clk); #1;
    ret(1, 1);
    @(negedge clk);
    vectors++;
    if (b.t_valid_inp1 !== 1'b0 || b.inflight !== 2'd1) begin
      miscompares++; $display("FAIL limit_return valid=%b inflight=%0d required=0,1", b.t_valid_inp1, b.inflight);
    end
    @(negedge clk);
    exp = {qb1.pop_front(), qb2.pop_front()};
    vectors++;
    if (b.t_valid_inp1 !== 1'b1 || {b.inp1, b.inp2} !== exp || b.inflight !== 2'd2) begin
      miscompares++;
      $display("FAIL limit_third valid=%b data=%h inflight=%0d required=1 %h 2",
               b.t_valid_inp1, {b.inp1, b.inp2}, b.inflight, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_op_change();
    logic [127:0] exp;
    clear_obs();
    fork
      for (int i = 0; i < 3; i++) push_pair(0, 64'h300 + 64'(i), 64'h400 + 64'(i));
      collect(0, 8);
    join
    vectors++;
    if (obs_d.size() != 3 || a.inflight !== 5'd3) begin
      miscompares++; $display("FAIL opchg_pre got=%0d pairs inflight=%0d required=3,3", obs_d.size(), a.inflight);
    end
    for (int i = 0; i < 3; i++) begin void'(q1.pop_front()); void'(q2.pop_front()); end
    @(posedge clk); #1;
    clear_obs();
    a.cfg_op = 2'b10; a.cfg_op_valid = 1;
    fork
      begin push_pair(0, 64'h500, 64'h600); push_pair(0, 64'h501, 64'h601); end
      collect(0, 40);
      begin cyc(6); ret(0, 3); end
      begin
        for (int t = 0; t < 38; t++) begin
          @(negedge clk);
          if (a.cfg_op_ready === 1'b1) break;
        end
        @(posedge clk); #1;
        a.cfg_op_valid = 0;
      end
    join
    vectors++;
    if (rdy_cnt != 1 || a.op !== 2'b10) begin
      miscompares++; $display("FAIL opchg_ready pulses=%0d op=%0d required=1,2", rdy_cnt, a.op);
    end
    vectors++;
    if (obs_d.size() != 2 || (obs_d.size() > 0 && obs_cyc[0] < 10)) begin
      miscompares++; $display("FAIL opchg_count got=%0d pairs required=2 after drain", obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp = {q1.pop_front(), q2.pop_front()};
      vectors++;
      if (obs_d[i] !== exp || obs_op[i] !== 2'b10) begin
        miscompares++; $display("FAIL opchg_pair%0d got=%h op=%0d required=%h op=2", i, obs_d[i], obs_op[i], exp);
      end
    end
    @(posedge clk); #1;
    ret(0, 2);
  endtask

  task automatic test_underflow();
    @(negedge clk);
    vectors++;
    if (a.inflight !== 5'd0 || a.err_underflow !== 1'b0) begin
      miscompares++; $display("FAIL uflow_pre inflight=%0d err=%b required=0,0", a.inflight, a.err_underflow);
    end
    @(posedge clk); #1;
    ret(0, 1);
    @(negedge clk);
    vectors++;
    if (a.err_underflow !== 1'b1 || a.inflight !== 5'd0) begin
      miscompares++; $display("FAIL uflow_set err=%b inflight=%0d required=1,0", a.err_underflow, a.inflight);
    end
    cyc(3);
    @(negedge clk);
    vectors++;
    if (a.err_underflow !== 1'b1) begin
      miscompares++; $display("FAIL uflow_sticky err=%b required=1", a.err_underflow);
    end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    vectors++;
    if (a.err_underflow !== 1'b0) begin
      miscompares++; $display("FAIL uflow_clear err=%b required=0", a.err_underflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_reset();
    logic [127:0] exp;
    for (int i = 0; i < 4; i++) push_one(1, 64'h31 + 64'(i));
    @(negedge clk);
    vectors++;
    if (a.s_inp1_tready !== 1'b0 || a.s_inp2_tready !== 1'b1) begin
      miscompares++; $display("FAIL full_tready got=%b%b required=01", a.s_inp1_tready, a.s_inp2_tready);
    end
    @(posedge clk); #1;
    a.s_inp1_tdata = 64'h35; a.s_inp1_tvalid = 1;
    do_reset();
    a.s_inp1_tvalid = 0;
    @(negedge clk);
    vectors++;
    if ({a.s_inp1_tready, a.s_inp2_tready, a.t_valid_inp1, a.t_valid_inp2, a.op} !== 6'b110000 ||
        a.inflight !== 5'd0) begin
      miscompares++;
      $display("FAIL full_after_rst got=%b inflight=%0d required=110000 0",
               {a.s_inp1_tready, a.s_inp2_tready, a.t_valid_inp1, a.t_valid_inp2, a.op}, a.inflight);
    end
    @(posedge clk); #1;
    clear_obs();
    fork push_one(2, 64'h41); collect(0, 5); join
    vectors++;
    if (obs_d.size() != 0) begin
      miscompares++; $display("FAIL full_flushed got=%0d pairs required=0", obs_d.size());
    end
    @(posedge clk); #1;
    fork push_one(1, 64'h51); collect(0, 5); join
    exp = {q1.pop_front(), q2.pop_front()};
    vectors++;
    if (obs_d.size() != 1 || obs_d[0] !== exp) begin
      miscompares++; $display("FAIL full_repair got=%0d pairs first=%h required=1 %h",
                              obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 128'd0, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached required=finish");
    $fatal(1);
  end

  initial begin
    a.s_inp1_tdata = '0; a.s_inp1_tvalid = 0; a.s_inp2_tdata = '0; a.s_inp2_tvalid = 0;
    a.cfg_op = 2'b00; a.cfg_op_valid = 0; a.pe_result_valid = 0;
    b.s_inp1_tdata = '0; b.s_inp1_tvalid = 0; b.s_inp2_tdata = '0; b.s_inp2_tvalid = 0;
    b.cfg_op = 2'b00; b.cfg_op_valid = 0; b.pe_result_valid = 0;
    test_reset();
    test_basic_pairs();
    test_lone_operand();
    test_inflight_limit();
    test_op_change();
    test_underflow();
    test_full_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
